rca_config_loader: RTL and testbench

// - Sequences programming of the RCA configuration register file from a packed config-word stream (CSR/DMA fed).
// - Per command (target RCA id): gates on target idle, then decodes one word per handshake into exactly one config-reg write strobe.
// - Also drives rca_sel_issue. Sits between the config-word source and rca_config_regs; the issue stage reads busy_o to stall RCA instrs.

---
 rtl/rca_config_loader_pkg.sv | 85 ++++++++
 rtl/rca_config_loader_decoder.sv | 70 +++++++
 rtl/rca_config_loader.sv | 194 +++++++++++++++++++
 tb/tb_rca_config_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_config_loader_pkg.sv
// Shared types and constants for the RCA configuration loader.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Holds the fixed RCA/core configuration, the config-word layout, the op
// encoding, the loader FSM states and the write-strobe bit positions.
package rca_config_loader_pkg;

    // Core / RCA configuration (fixed for this build, not overridable)
    localparam int NUM_RCAS        = 4;
    localparam int NUM_IO_UNITS    = 4;
    localparam int NUM_READ_PORTS  = 4;
    localparam int NUM_WRITE_PORTS = 2;
    localparam int NUM_GRID_MUXES  = 16;
    localparam int XLEN            = 32;

    localparam int CFG_MAX_WORDS   = 64;

    localparam int RCA_ID_W = $clog2(NUM_RCAS);
    localparam int PORT_W   = $clog2(NUM_READ_PORTS);
    localparam int IO_W     = $clog2(NUM_IO_UNITS);
    localparam int TBL_W    = $clog2(NUM_GRID_MUXES);
    localparam int REG_W    = 5;
    localparam int CNT_W    = $clog2(CFG_MAX_WORDS + 1);

    typedef enum logic [3:0] {
        OP_END      = 4'd0,
        OP_SRC      = 4'd1,
        OP_DEST_FB  = 4'd2,
        OP_DEST_NFB = 4'd3,
        OP_GRID_MUX = 4'd4,
        OP_IO_MUX   = 4'd5,
        OP_RES_FB   = 4'd6,
        OP_RES_NFB  = 4'd7,
        OP_INP_MAP  = 4'd8,
        OP_CONST    = 4'd9,
        OP_LS_FB    = 4'd10,
        OP_LS_NFB   = 4'd11
    } rca_cfg_op_t;

    typedef struct packed {
        rca_cfg_op_t  op;
        logic [11:0]  addr;
        logic [15:0]  data;
    } rca_cfg_word_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        FETCH,
        CONST_DATA,
        DONE,
        ERR
    } loader_state_t;

    // Bit positions inside the one-hot write-strobe vector
    localparam int STB_CPU_FB   = 0;
    localparam int STB_CPU_NFB  = 1;
    localparam int STB_GRID_MUX = 2;
    localparam int STB_IO_MUX   = 3;
    localparam int STB_RES_FB   = 4;
    localparam int STB_RES_NFB  = 5;
    localparam int STB_INP_MAP  = 6;
    localparam int STB_CONST    = 7;
    localparam int STB_LS_FB    = 8;
    localparam int STB_LS_NFB   = 9;
    localparam int NUM_STB      = 10;

    typedef logic [NUM_STB-1:0] cfg_stb_t;

    // Number of entries in the table an op writes; addr must be below it.
    // Zero for ops that address no table.
    function automatic logic [11:0] op_addr_limit(input rca_cfg_op_t op);
        case (op)
            OP_SRC:                                      return 12'(NUM_READ_PORTS);
            OP_DEST_FB, OP_DEST_NFB, OP_RES_FB,
            OP_RES_NFB:                                  return 12'(NUM_WRITE_PORTS);
            OP_GRID_MUX:                                 return 12'(NUM_GRID_MUXES);
            OP_IO_MUX, OP_INP_MAP, OP_CONST, OP_LS_FB,
            OP_LS_NFB:                                   return 12'(NUM_IO_UNITS);
            default:                                     return 12'd0;
        endcase
    endfunction

endpackage

// File: rtl/rca_config_loader_decoder.sv
// Decodes one config word into a one-hot write strobe, payload fields and error flags.
// Latency: combinational.
// Backpressure: none; the loader decides whether the word is accepted.
//
// Ports: word_i (packed config word) -> stb_o (one-hot, zero on any error),
// is_end_o / is_const_hdr_o (sequence control), op_err_o (unknown op),
// range_err_o (addr outside target table), payload fields.
module rca_cfg_word_decoder
    import rca_config_loader_pkg::*;
(
    input  rca_cfg_word_t       word_i,
    output cfg_stb_t            stb_o,
    output logic                is_end_o,
    output logic                is_const_hdr_o,
    output logic                op_err_o,
    output logic                range_err_o,
    output logic                src_dest_port_o,
    output logic [PORT_W-1:0]   port_addr_o,
    output logic [REG_W-1:0]    reg_addr_o,
    output logic [TBL_W-1:0]    tbl_addr_o,
    output logic [15:0]         tbl_data_o,
    output logic [IO_W-1:0]     io_unit_o
);

    cfg_stb_t stb_sel;
    logic     has_table;

    always_comb begin
        stb_sel         = '0;
        has_table       = 1'b1;
        is_end_o        = 1'b0;
        is_const_hdr_o  = 1'b0;
        op_err_o        = 1'b0;
        src_dest_port_o = 1'b0;
        case (word_i.op)
            OP_END: begin
                is_end_o  = 1'b1;
                has_table = 1'b0;
            end
            OP_SRC:      stb_sel[STB_CPU_FB] = 1'b1;
            OP_DEST_FB: begin
                // SRC and DEST_FB share the fb reg-addr table, split by port select
                stb_sel[STB_CPU_FB] = 1'b1;
                src_dest_port_o     = 1'b1;
            end
            OP_DEST_NFB: stb_sel[STB_CPU_NFB]  = 1'b1;
            OP_GRID_MUX: stb_sel[STB_GRID_MUX] = 1'b1;
            OP_IO_MUX:   stb_sel[STB_IO_MUX]   = 1'b1;
            OP_RES_FB:   stb_sel[STB_RES_FB]   = 1'b1;
            OP_RES_NFB:  stb_sel[STB_RES_NFB]  = 1'b1;
            OP_INP_MAP:  stb_sel[STB_INP_MAP]  = 1'b1;
            OP_CONST:    is_const_hdr_o        = 1'b1;  // strobe comes with the data word
            OP_LS_FB:    stb_sel[STB_LS_FB]    = 1'b1;
            OP_LS_NFB:   stb_sel[STB_LS_NFB]   = 1'b1;
            default: begin
                op_err_o  = 1'b1;
                has_table = 1'b0;
            end
        endcase
        range_err_o = has_table && (word_i.addr >= op_addr_limit(word_i.op));
        stb_o       = range_err_o ? '0 : stb_sel;
    end

    assign port_addr_o = word_i.addr[PORT_W-1:0];
    assign reg_addr_o  = word_i.data[REG_W-1:0];
    assign tbl_addr_o  = word_i.addr[TBL_W-1:0];
    assign tbl_data_o  = word_i.data;
    assign io_unit_o   = word_i.addr[IO_W-1:0];

endmodule

// File: rtl/rca_config_loader.sv
// Sequences RCA config-register programming from a config-word stream, one command per target RCA.
// Latency: a write strobe and its payload appear one cycle after the word is accepted.
// Backpressure: start_ready only in IDLE; cfg_ready only in FETCH/CONST_DATA and once the target RCA is idle.
//
// Ports: start_valid/start_ready/start_rca_id (command), rca_active (per-RCA in-flight),
// cfg_word/cfg_valid/cfg_ready (word stream), busy_o/done_o/err_o (status),
// rca_sel_issue (latched target), *_wr_en strobes and registered payloads to the config regs.
module rca_config_loader
    import rca_config_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [RCA_ID_W-1:0]   start_rca_id,
    input  logic [NUM_RCAS-1:0]   rca_active,
    input  logic [XLEN-1:0]       cfg_word,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [RCA_ID_W-1:0]   rca_sel_issue,
    output logic                  cpu_fb_reg_addr_wr_en,
    output logic                  cpu_nfb_reg_addr_wr_en,
    output logic                  grid_mux_wr_en,
    output logic                  io_mux_wr_en,
    output logic                  rca_fb_result_mux_wr_en,
    output logic                  rca_nfb_result_mux_wr_en,
    output logic                  rca_io_inp_map_wr_en,
    output logic                  rca_input_constants_wr_en,
    output logic                  rca_io_ls_mask_fb_wr_en,
    output logic                  rca_io_ls_mask_wr_en,
    output logic                  src_dest_port,
    output logic [PORT_W-1:0]     cpu_port_addr,
    output logic [REG_W-1:0]      cpu_reg_addr,
    output logic [TBL_W-1:0]      cfg_tbl_addr,
    output logic [15:0]           cfg_tbl_data,
    output logic [IO_W-1:0]       io_unit_addr,
    output logic [XLEN-1:0]       new_input_constant
);

    loader_state_t          state_q, state_d;
    logic [RCA_ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_next;
    cfg_stb_t               stb_q, stb_d;
    logic                   sdp_q, sdp_d;
    logic [PORT_W-1:0]      port_q, port_d;
    logic [REG_W-1:0]       reg_q, reg_d;
    logic [TBL_W-1:0]       tbl_addr_q, tbl_addr_d;
    logic [15:0]            tbl_data_q, tbl_data_d;
    logic [IO_W-1:0]        io_q, io_d;
    logic [XLEN-1:0]        const_q, const_d;

    cfg_stb_t               dec_stb;
    logic                   dec_end, dec_const_hdr, dec_op_err, dec_range_err, dec_sdp;
    logic [PORT_W-1:0]      dec_port;
    logic [REG_W-1:0]       dec_reg;
    logic [TBL_W-1:0]       dec_tbl_addr;
    logic [15:0]            dec_tbl_data;
    logic [IO_W-1:0]        dec_io;
    logic                   word_acc;

    rca_cfg_word_decoder u_dec (
        .word_i          (rca_cfg_word_t'(cfg_word)),
        .stb_o           (dec_stb),
        .is_end_o        (dec_end),
        .is_const_hdr_o  (dec_const_hdr),
        .op_err_o        (dec_op_err),
        .range_err_o     (dec_range_err),
        .src_dest_port_o (dec_sdp),
        .port_addr_o     (dec_port),
        .reg_addr_o      (dec_reg),
        .tbl_addr_o      (dec_tbl_addr),
        .tbl_data_o      (dec_tbl_data),
        .io_unit_o       (dec_io)
    );

    assign start_ready = (state_q == IDLE);
    assign cfg_ready   = (state_q == FETCH) || (state_q == CONST_DATA);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);
    assign word_acc    = cfg_valid && cfg_ready;
    assign cnt_next    = cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        stb_d      = '0;
        sdp_d      = sdp_q;
        port_d     = port_q;
        reg_d      = reg_q;
        tbl_addr_d = tbl_addr_q;
        tbl_data_d = tbl_data_q;
        io_d       = io_q;
        const_d    = const_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    id_d    = start_rca_id;
                    cnt_d   = '0;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!rca_active[id_q]) state_d = FETCH;
            end
            FETCH: begin
                if (word_acc) begin
                    cnt_d = cnt_next;
                    if (dec_end) begin
                        state_d = DONE;
                    end else if (dec_op_err || dec_range_err) begin
                        state_d = ERR;  // bad word writes nothing
                    end else begin
                        stb_d      = dec_stb;
                        sdp_d      = dec_sdp;
                        port_d     = dec_port;
                        reg_d      = dec_reg;
                        tbl_addr_d = dec_tbl_addr;
                        tbl_data_d = dec_tbl_data;
                        if (dec_const_hdr) begin
                            io_d    = dec_io;
                            state_d = CONST_DATA;
                        end
                        // The word that uses up the budget still takes effect
                        if (cnt_next == CNT_W'(CFG_MAX_WORDS)) state_d = ERR;
                    end
                end
            end
            CONST_DATA: begin
                if (word_acc) begin
                    cnt_d              = cnt_next;
                    stb_d[STB_CONST]   = 1'b1;
                    const_d            = cfg_word;
                    state_d            = (cnt_next == CNT_W'(CFG_MAX_WORDS)) ? ERR : FETCH;
                end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= '0;
            cnt_q      <= '0;
            stb_q      <= '0;
            sdp_q      <= 1'b0;
            port_q     <= '0;
            reg_q      <= '0;
            tbl_addr_q <= '0;
            tbl_data_q <= '0;
            io_q       <= '0;
            const_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            stb_q      <= stb_d;
            sdp_q      <= sdp_d;
            port_q     <= port_d;
            reg_q      <= reg_d;
            tbl_addr_q <= tbl_addr_d;
            tbl_data_q <= tbl_data_d;
            io_q       <= io_d;
            const_q    <= const_d;
        end
    end

    assign rca_sel_issue             = id_q;
    assign cpu_fb_reg_addr_wr_en     = stb_q[STB_CPU_FB];
    assign cpu_nfb_reg_addr_wr_en    = stb_q[STB_CPU_NFB];
    assign grid_mux_wr_en            = stb_q[STB_GRID_MUX];
    assign io_mux_wr_en              = stb_q[STB_IO_MUX];
    assign rca_fb_result_mux_wr_en   = stb_q[STB_RES_FB];
    assign rca_nfb_result_mux_wr_en  = stb_q[STB_RES_NFB];
    assign rca_io_inp_map_wr_en      = stb_q[STB_INP_MAP];
    assign rca_input_constants_wr_en = stb_q[STB_CONST];
    assign rca_io_ls_mask_fb_wr_en   = stb_q[STB_LS_FB];
    assign rca_io_ls_mask_wr_en      = stb_q[STB_LS_NFB];
    assign src_dest_port             = sdp_q;
    assign cpu_port_addr             = port_q;
    assign cpu_reg_addr              = reg_q;
    assign cfg_tbl_addr              = tbl_addr_q;
    assign cfg_tbl_data              = tbl_data_q;
    assign io_unit_addr              = io_q;
    assign new_input_constant        = const_q;

endmodule

// File: tb/tb_rca_config_loader.sv
module tb_rca_config_loader;
    import rca_config_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  start_rca_id = 2'd0;
    logic [3:0]  rca_active = 4'd0;
    logic [31:0] cfg_word = 32'd0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        busy_o, done_o, err_o;
    logic [1:0]  rca_sel_issue;
    logic        cpu_fb_reg_addr_wr_en, cpu_nfb_reg_addr_wr_en, grid_mux_wr_en, io_mux_wr_en;
    logic        rca_fb_result_mux_wr_en, rca_nfb_result_mux_wr_en, rca_io_inp_map_wr_en;
    logic        rca_input_constants_wr_en, rca_io_ls_mask_fb_wr_en, rca_io_ls_mask_wr_en;
    logic        src_dest_port;
    logic [1:0]  cpu_port_addr;
    logic [4:0]  cpu_reg_addr;
    logic [3:0]  cfg_tbl_addr;
    logic [15:0] cfg_tbl_data;
    logic [1:0]  io_unit_addr;
    logic [31:0] new_input_constant;
    logic [9:0]  stb;

    typedef struct {
        int          idx;
        logic [63:0] pl;
        int          cyc;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  blocked_viol = 0;
    bit  blocking = 1'b0;
    wr_t obs_q[$];

    always #5 clk = ~clk;

    rca_config_loader dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready), .start_rca_id(start_rca_id),
        .rca_active(rca_active),
        .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rca_sel_issue(rca_sel_issue),
        .cpu_fb_reg_addr_wr_en(cpu_fb_reg_addr_wr_en), .cpu_nfb_reg_addr_wr_en(cpu_nfb_reg_addr_wr_en),
        .grid_mux_wr_en(grid_mux_wr_en), .io_mux_wr_en(io_mux_wr_en),
        .rca_fb_result_mux_wr_en(rca_fb_result_mux_wr_en),
        .rca_nfb_result_mux_wr_en(rca_nfb_result_mux_wr_en),
        .rca_io_inp_map_wr_en(rca_io_inp_map_wr_en),
        .rca_input_constants_wr_en(rca_input_constants_wr_en),
        .rca_io_ls_mask_fb_wr_en(rca_io_ls_mask_fb_wr_en), .rca_io_ls_mask_wr_en(rca_io_ls_mask_wr_en),
        .src_dest_port(src_dest_port), .cpu_port_addr(cpu_port_addr), .cpu_reg_addr(cpu_reg_addr),
        .cfg_tbl_addr(cfg_tbl_addr), .cfg_tbl_data(cfg_tbl_data),
        .io_unit_addr(io_unit_addr), .new_input_constant(new_input_constant)
    );

    assign stb = {rca_io_ls_mask_wr_en, rca_io_ls_mask_fb_wr_en, rca_input_constants_wr_en,
                  rca_io_inp_map_wr_en, rca_nfb_result_mux_wr_en, rca_fb_result_mux_wr_en,
                  io_mux_wr_en, grid_mux_wr_en, cpu_nfb_reg_addr_wr_en, cpu_fb_reg_addr_wr_en};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Payload seen by the config regs for a given strobe
    function automatic logic [63:0] dut_pl(input int idx);
        case (idx)
            STB_CPU_FB:  return 64'({src_dest_port, cpu_port_addr, cpu_reg_addr});
            STB_CPU_NFB: return 64'({cpu_port_addr, cpu_reg_addr});
            STB_CONST:   return 64'({io_unit_addr, new_input_constant});
            default:     return 64'({cfg_tbl_addr, cfg_tbl_data});
        endcase
    endfunction

    // One clock; outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        wr_t r;
        @(posedge clk);
        #1;
        cyc++;
        chk("onehot0", 64'($onehot0(stb)), 64'd1);
        if (blocking && (cfg_ready || (|stb))) blocked_viol++;
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
        if (|stb) begin
            r.idx = 0;
            for (int i = 9; i >= 0; i--) if (stb[i]) r.idx = i;
            r.pl  = dut_pl(r.idx);
            r.cyc = cyc;
            obs_q.push_back(r);
        end
    endtask

    // Reference: interpret a program word by word and list the register writes it must cause
    function automatic void model(input logic [31:0] w[$], output wr_t e[$],
                                  output int ndone, output int nerr, output int used);
        int cnt;
        int i;
        int lim;
        logic [3:0]  op;
        logic [11:0] a;
        logic [15:0] d;
        wr_t r;
        cnt = 0; i = 0; ndone = 0; nerr = 0;
        e.delete();
        r.cyc = 0;
        while (i < w.size()) begin
            op = w[i][31:28]; a = w[i][27:16]; d = w[i][15:0];
            i++; cnt++;
            if (op == 4'd0) begin ndone = 1; break; end
            case (op)
                4'd1:                    lim = NUM_READ_PORTS;
                4'd2, 4'd3, 4'd6, 4'd7:  lim = NUM_WRITE_PORTS;
                4'd4:                    lim = NUM_GRID_MUXES;
                4'd5, 4'd8, 4'd9, 4'd10,
                4'd11:                   lim = NUM_IO_UNITS;
                default:                 lim = -1;
            endcase
            if (lim < 0 || int'(a) >= lim) begin nerr = 1; break; end
            if (op == 4'd9) begin
                if (cnt >= CFG_MAX_WORDS) begin nerr = 1; break; end
                r.idx = STB_CONST;
                r.pl  = 64'({a[1:0], w[i]});
                i++; cnt++;
            end else begin
                case (op)
                    4'd1, 4'd2: r.idx = STB_CPU_FB;
                    4'd3:       r.idx = STB_CPU_NFB;
                    4'd4:       r.idx = STB_GRID_MUX;
                    4'd5:       r.idx = STB_IO_MUX;
                    4'd6:       r.idx = STB_RES_FB;
                    4'd7:       r.idx = STB_RES_NFB;
                    4'd8:       r.idx = STB_INP_MAP;
                    4'd10:      r.idx = STB_LS_FB;
                    default:    r.idx = STB_LS_NFB;
                endcase
                if (op <= 4'd2)      r.pl = 64'({op == 4'd2, a[1:0], d[4:0]});
                else if (op == 4'd3) r.pl = 64'({a[1:0], d[4:0]});
                else                 r.pl = 64'({a[3:0], d});
            end
            e.push_back(r);
            if (cnt >= CFG_MAX_WORDS) begin nerr = 1; break; end
        end
        used = i;
    endfunction

    // Run one command end to end and compare against the reference
    task automatic run_cmd(input string tag, input logic [1:0] id, input logic [31:0] words[$],
                           input int active_cyc, input int gap_pct);
        int  n, act_left, wi, budget, ndone, nerr, used;
        wr_t exp_q[$];
        obs_q.delete();
        done_cnt = 0; err_cnt = 0; blocked_viol = 0;
        start_valid  = 1'b1;
        start_rca_id = id;
        rca_active   = 4'($urandom);
        rca_active[id] = (active_cyc > 0);
        n = 0;
        while (!start_ready && n < 50) begin tick(); n++; end
        tick();
        start_valid = 1'b0;
        act_left = active_cyc; wi = 0; budget = 0;
        while ((done_cnt + err_cnt) == 0 && budget < 3000) begin
            blocking = (act_left > 0);
            if (act_left == 0) rca_active[id] = 1'b0;
            if (wi < words.size() && $urandom_range(0, 99) >= gap_pct) begin
                cfg_valid = 1'b1;
                cfg_word  = words[wi];
            end else begin
                cfg_valid = 1'b0;
                cfg_word  = $urandom;
            end
            if (cfg_valid && cfg_ready) wi++;
            tick();
            if (act_left > 0) act_left--;
            budget++;
        end
        blocking   = 1'b0;
        cfg_valid  = 1'b0;
        rca_active = 4'd0;
        chk({tag, " finished"}, 64'((done_cnt + err_cnt) > 0), 64'd1);
        chk({tag, " sel"}, 64'(rca_sel_issue), 64'(id));
        tick();
        tick();
        model(words, exp_q, ndone, nerr, used);
        chk({tag, " nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            chk({tag, " wr_idx"}, 64'(obs_q[k].idx), 64'(exp_q[k].idx));
            chk({tag, " wr_pl"}, obs_q[k].pl, exp_q[k].pl);
        end
        chk({tag, " done"}, 64'(done_cnt), 64'(ndone));
        chk({tag, " err"}, 64'(err_cnt), 64'(nerr));
        chk({tag, " used"}, 64'(wi), 64'(used));
        chk({tag, " blocked"}, 64'(blocked_viol), 64'd0);
        chk({tag, " busy_after"}, 64'(busy_o), 64'd0);
        chk({tag, " start_rdy_after"}, 64'(start_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] prog[$];
        int len;
        logic [3:0] op;
        logic [11:0] addr;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst busy", 64'(busy_o), 64'd0);
        chk("rst done", 64'(done_o), 64'd0);
        chk("rst err", 64'(err_o), 64'd0);
        chk("rst start_ready", 64'(start_ready), 64'd1);
        chk("rst cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst sel", 64'(rca_sel_issue), 64'd0);
        chk("rst strobes", 64'(stb), 64'd0);

        // Full program of RCA 1, words back to back
        prog = '{{4'd1, 12'd0, 16'd5}, {4'd2, 12'd0, 16'd7}, {4'd4, 12'd3, 16'd2}, 32'd0};
        run_cmd("rca1", 2'd1, prog, 0, 0);
        if (obs_q.size() == 3) begin
            chk("rca1 consec01", 64'(obs_q[1].cyc - obs_q[0].cyc), 64'd1);
            chk("rca1 consec12", 64'(obs_q[2].cyc - obs_q[1].cyc), 64'd1);
        end

        // Target busy for 10 cycles before the stream may start
        prog = '{{4'd5, 12'd1, 16'h0003}, {4'd11, 12'd2, 16'h00F0}, 32'd0};
        run_cmd("rca2 busy", 2'd2, prog, 10, 0);

        // Constant load with gaps in cfg_valid
        prog = '{{4'd9, 12'd1, 16'd0}, 32'hDEADBEEF, 32'd0};
        run_cmd("const", 2'd0, prog, 0, 50);
        if (obs_q.size() == 1) begin
            chk("const io", 64'(io_unit_addr), 64'd1);
            chk("const val", 64'(new_input_constant), 64'hDEADBEEF);
        end

        // Illegal op mid-stream
        prog = '{{4'd1, 12'd3, 16'd9}, {4'd10, 12'd2, 16'h000F}, {4'hE, 12'd0, 16'd0},
                 {4'd4, 12'd1, 16'd1}, 32'd0};
        run_cmd("bad op", 2'd3, prog, 0, 20);

        // Result-mux port one past the last write port
        prog = '{{4'd6, 12'd1, 16'd2}, {4'd7, 12'(NUM_WRITE_PORTS), 16'd1}, 32'd0};
        run_cmd("res port", 2'd1, prog, 0, 0);

        // 65 words with no END
        prog.delete();
        for (int k = 0; k < 65; k++) prog.push_back({4'd4, 12'($urandom_range(0, 15)), 16'($urandom)});
        run_cmd("max words", 2'd2, prog, 0, 10);

        // Reset with a write strobe pending
        start_valid  = 1'b1;
        start_rca_id = 2'd3;
        rca_active   = 4'd0;
        tick();
        start_valid = 1'b0;
        cfg_valid   = 1'b1;
        cfg_word    = {4'd5, 12'd2, 16'h0055};
        tick();
        tick();
        chk("pending strobe", 64'(io_mux_wr_en), 64'd1);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        tick();
        chk("midrst strobes", 64'(stb), 64'd0);
        chk("midrst busy", 64'(busy_o), 64'd0);
        chk("midrst cfg_ready", 64'(cfg_ready), 64'd0);
        chk("midrst start_ready", 64'(start_ready), 64'd1);
        rst = 1'b0;

        // Random programs
        for (int t = 0; t < 24; t++) begin
            prog.delete();
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 11) == 0) op = 4'($urandom_range(12, 15));
                else                            op = 4'($urandom_range(1, 11));
                if ($urandom_range(0, 9) < 8) addr = 12'($urandom_range(0, 3));
                else                          addr = 12'($urandom_range(0, 20));
                prog.push_back({op, addr, 16'($urandom)});
                if (op == 4'd9) prog.push_back($urandom);
            end
            prog.push_back(32'd0);
            run_cmd("random", 2'($urandom_range(0, 3)), prog,
                    $urandom_range(0, 3), $urandom_range(0, 40));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
